// File: rtl/segment_match_collector.sv
// Collects per-fragment segment bitmaps, ANDs them and priority-encodes the lowest hit.
// Optional SEG_HIT_COUNT_EN adds a saturating hit counter on o_hit_count.
module segment_match_collector #(
  parameter int DATA_BITS = 10,
  parameter int FRAGMENTS = 5,
  parameter int FRAG_BITS = 3,
  parameter int ENTRIES   = 16,
  parameter int IDX_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic                 i_rd_valid,
  input  logic [FRAG_BITS-1:0] i_rd_frag,
  input  logic [ENTRIES-1:0]   i_rd_data,
  output logic                 o_busy,
  output logic                 o_match_valid,
  output logic [ENTRIES-1:0]   o_match_vector,
  output logic                 o_match_hit,
  output logic [IDX_BITS-1:0]  o_match_index,
  output logic                 o_frag_error
`ifdef SEG_HIT_COUNT_EN
  ,
  output logic [15:0]          o_hit_count
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]           r_state;
  logic [FRAG_BITS-1:0] r_cnt;
  logic [ENTRIES-1:0]   r_acc;
  logic                 r_valid;
  logic [ENTRIES-1:0]   r_vec;
  logic                 r_hit;
  logic [IDX_BITS-1:0]  r_idx;
  logic                 r_err;

  logic [ENTRIES-1:0]   w_and;
  logic                 w_tag_ok;
  logic                 w_last;
  logic [IDX_BITS-1:0]  w_idx;

  assign w_and    = r_acc & i_rd_data;
  assign w_tag_ok = (i_rd_frag == r_cnt);
  assign w_last   = (r_cnt == FRAG_BITS'(FRAGMENTS - 1));

  // Scan high to low so the lowest set bit is the one that sticks
  always_comb begin
    w_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_and[i]) w_idx = IDX_BITS'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '1;
      r_valid <= 1'b0;
      r_vec   <= '0;
      r_hit   <= 1'b0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_start) begin
        r_state <= S_COLLECT;
        r_cnt   <= '0;
        r_acc   <= '1;
        r_err   <= 1'b0;
      end else begin
        unique case (r_state)
          S_COLLECT: begin
            if (i_rd_valid) begin
              if (w_tag_ok) begin
                r_acc <= w_and;
                if (w_last) begin
                  r_state <= S_DONE;
                  r_valid <= 1'b1;
                  r_vec   <= w_and;
                  r_hit   <= |w_and;
                  r_idx   <= w_idx;
                end else begin
                  r_cnt <= r_cnt + 1'b1;
                end
              end else begin
                r_state <= S_DONE;
                r_valid <= 1'b1;
                r_err   <= 1'b1;
                r_vec   <= '0;
                r_hit   <= 1'b0;
                r_idx   <= '0;
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SEG_HIT_COUNT_EN
  logic [15:0] r_hit_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_cnt <= '0;
    end else if ((r_state == S_DONE) && r_hit && (r_hit_cnt != 16'hFFFF)) begin
      r_hit_cnt <= r_hit_cnt + 16'd1;
    end
  end

  assign o_hit_count = r_hit_cnt;
`endif

  assign o_busy         = (r_state != S_IDLE);
  assign o_match_valid  = r_valid;
  assign o_match_vector = r_vec;
  assign o_match_hit    = r_hit;
  assign o_match_index  = r_idx;
  assign o_frag_error   = r_err;

endmodule

// File: tb/tb_segment_match_collector.sv
// Randomized bench for segment_match_collector against a lookup-level model.
// Define SEG_HIT_COUNT_EN to also exercise o_hit_count.
module tb_segment_match_collector;

  localparam int FRAGMENTS = 5;

  logic        clk = 1'b0;
  logic        d_rst = 1'b1;
  logic        d_start = 1'b0;
  logic        d_v = 1'b0;
  logic [2:0]  d_frag = '0;
  logic [15:0] d_data = '0;
  logic        o_busy, o_match_valid, o_match_hit, o_frag_error;
  logic [15:0] o_match_vector;
  logic [3:0]  o_match_index;
`ifdef SEG_HIT_COUNT_EN
  logic [15:0] o_hit_count;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  segment_match_collector dut (
    .clk           (clk),
    .reset         (d_rst),
    .i_start       (d_start),
    .i_rd_valid    (d_v),
    .i_rd_frag     (d_frag),
    .i_rd_data     (d_data),
    .o_busy        (o_busy),
    .o_match_valid (o_match_valid),
    .o_match_vector(o_match_vector),
    .o_match_hit   (o_match_hit),
    .o_match_index (o_match_index),
    .o_frag_error  (o_frag_error)
`ifdef SEG_HIT_COUNT_EN
    ,
    .o_hit_count   (o_hit_count)
`endif
  );

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  // Model: 0 idle, 1 collecting, 2 result cycle; accepted words kept in a queue
  int          m_phase = 0;
  logic [15:0] m_q[$];
  logic        e_valid = 0, e_hit = 0, e_err = 0;
  logic [15:0] e_vec = 0;
  logic [3:0]  e_idx = 0;
  logic [15:0] e_cnt = 0;

  task automatic finish_lookup();
    logic [15:0] v;
    v = 16'hFFFF;
    foreach (m_q[k]) v = v & m_q[k];
    e_vec = v;
    e_hit = (v != 0);
    e_idx = 0;
    for (int b = 0; b < 16; b++) begin
      if (v[b]) begin
        e_idx = 4'(b);
        break;
      end
    end
    e_valid = 1;
    m_phase = 2;
  endtask

  always @(posedge clk) begin
    if (d_rst) begin
      m_phase = 0;
      m_q.delete();
      e_valid = 0; e_hit = 0; e_err = 0; e_vec = 0; e_idx = 0; e_cnt = 0;
    end else begin
      if (m_phase == 2 && e_hit && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
      e_valid = 0;
      if (d_start) begin
        m_phase = 1;
        m_q.delete();
        e_err = 0;
      end else if (m_phase == 1 && d_v) begin
        if (int'(d_frag) == m_q.size()) begin
          m_q.push_back(d_data);
          if (m_q.size() == FRAGMENTS) finish_lookup();
        end else begin
          e_err = 1; e_vec = 0; e_hit = 0; e_idx = 0;
          e_valid = 1;
          m_phase = 2;
        end
      end else if (m_phase == 2) begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", o_busy, m_phase != 0);
    check("valid", o_match_valid, e_valid);
    check("vector", o_match_vector, e_vec);
    check("hit", o_match_hit, e_hit);
    check("index", o_match_index, e_idx);
    check("frag_error", o_frag_error, e_err);
`ifdef SEG_HIT_COUNT_EN
    check("hit_count", o_hit_count, e_cnt);
`endif
  end

  task automatic cyc(input logic r, input logic s, input logic v,
                     input logic [2:0] f, input logic [15:0] d);
    @(negedge clk);
    d_rst = r; d_start = s; d_v = v; d_frag = f; d_data = d;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic lookup(input logic [15:0] d);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < FRAGMENTS; i++) cyc(0, 0, 1, 3'(i), d);
    idle();
    idle();
  endtask

  initial begin
    logic [15:0] pat[5];
    int r;
    repeat (2) @(negedge clk);
    idle();
    #1;
    check("t1_busy", o_busy, 0);
    check("t1_vec", o_match_vector, 0);
    check("t1_valid", o_match_valid, 0);
    check("t1_err", o_frag_error, 0);

    pat = '{16'hFFFF, 16'h00F0, 16'h0FF0, 16'hF0F0, 16'hFFF0};
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 3'(i), pat[i]);
    idle();
    #1;
    check("t2_valid", o_match_valid, 1);
    check("t2_vec", o_match_vector, 16'h00F0);
    check("t2_hit", o_match_hit, 1);
    check("t2_idx", o_match_index, 4);
    idle();
    #1;
    check("t2_pulse_end", o_match_valid, 0);
    check("t2_hold", o_match_vector, 16'h00F0);

    pat = '{16'h0001, 16'h0002, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 3'(i), pat[i]);
    idle();
    #1;
    check("t3_valid", o_match_valid, 1);
    check("t3_vec", o_match_vector, 0);
    check("t3_hit", o_match_hit, 0);
    check("t3_idx", o_match_index, 0);

    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 16'hFFFF);
    cyc(0, 0, 1, 1, 16'hFFFF);
    cyc(0, 0, 1, 3, 16'hFFFF);
    idle();
    #1;
    check("t4_valid", o_match_valid, 1);
    check("t4_err", o_frag_error, 1);
    check("t4_vec", o_match_vector, 0);
    idle();
    #1;
    check("t4_err_hold", o_frag_error, 1);
    cyc(0, 1, 0, 0, 0);
    idle();
    #1;
    check("t4_err_clr", o_frag_error, 0);

    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 3'(i), 16'hFFFF);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 3'(i), 16'h8000);
    idle();
    #1;
    check("t5_vec", o_match_vector, 16'h8000);
    check("t5_idx", o_match_index, 15);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 16'hFFFF);
    cyc(0, 0, 1, 1, 16'hFFFF);
    cyc(1, 0, 0, 0, 0);
    idle();
    #1;
    check("t5_rst_busy", o_busy, 0);
    check("t5_rst_vec", o_match_vector, 0);
    check("t5_rst_valid", o_match_valid, 0);

`ifdef SEG_HIT_COUNT_EN
    lookup(16'h0100);
    lookup(16'h0003);
    lookup(16'hFFFF);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 16'h0001);
    for (int i = 1; i < 5; i++) cyc(0, 0, 1, 3'(i), 16'h0002);
    idle();
    idle();
    #1;
    check("t6_count", o_hit_count, 3);
    @(negedge clk);
    force dut.r_hit_cnt = 16'hFFFF;
    e_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_hit_cnt;
    lookup(16'h0010);
    #1;
    check("t6_sat", o_hit_count, 16'hFFFF);
`endif

    for (int n = 0; n < 300; n++) begin
      cyc(0, 1, 0, 0, 16'($urandom));
      for (int c = 0; c < 40; c++) begin
        if (c > 0 && m_phase != 1) break;
        r = int'($urandom % 100);
        if (r < 1) begin
          cyc(1, 0, 0, 0, 0);
        end else if (r < 3) begin
          cyc(0, 1, $urandom % 2, 3'($urandom), 16'($urandom));
        end else if (r < 70) begin
          if ($urandom % 20 == 0)
            cyc(0, 0, 1, 3'($urandom), 16'($urandom) | 16'($urandom));
          else
            cyc(0, 0, 1, 3'(m_q.size()), 16'($urandom) | 16'($urandom));
        end else begin
          cyc(0, 0, 0, 3'($urandom), 16'($urandom));
        end
      end
      for (int k = 0; k < 3; k++) cyc(0, 0, $urandom % 2, 3'($urandom), 16'($urandom));
    end
    idle();
    idle();
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
